// File: rtl/mlblock_cfg_pkg.sv
// Shared state type and chain-length helper for the MLBlock configuration loader.
package mlblock_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cfg_state_e;

    // Chain length for an array: fixed control bits plus per-MAC bits for every unit in every block.
    function automatic int cfg_chain_len(
        input int i_d_half,
        input int res_d_cntl,
        input int bits_per_mac,
        input int mac_units,
        input int blocks
    );
        return i_d_half + res_d_cntl + bits_per_mac * mac_units * blocks;
    endfunction

endpackage

// File: rtl/mlblock_cfg_shifter.sv
// Parallel-in, MSB-first serial-out shift register with a shifted-bit counter.
// A load may coincide with a shift so the first bit leaves in the same cycle the word arrives.
module mlblock_cfg_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] word,
    output logic             msb,
    output logic             all_shifted
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] src;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_base;

    assign src         = load ? word : sr;
    assign cnt_base    = load ? '0 : cnt;
    assign msb         = src[WIDTH-1];
    assign all_shifted = (cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load || shift) begin
            sr  <= shift ? {src[WIDTH-2:0], 1'b0} : src;
            cnt <= shift ? cnt_base + CNT_W'(1) : cnt_base;
        end
    end

endmodule

// File: rtl/mlblock_config_loader.sv
// Serial writer for the MLBlock configuration chain; readback of the previous
// chain contents is built only when MLBLOCK_CFG_READBACK_EN is defined.
//
// state | meaning
// IDLE  | ready for a new word
// SHIFT | bits are being issued to the chain, paused while hold is high
// DONE  | all bits shifted, one-cycle done pulse
module mlblock_config_loader
    import mlblock_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHAIN_LEN-1:0] cfg_word,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 hold,
    output logic                 config_en,
    output logic                 config_in,
    input  logic                 config_out,
    output logic                 busy,
    output logic                 done
`ifdef MLBLOCK_CFG_READBACK_EN
    ,
    output logic [CHAIN_LEN-1:0] rb_word,
    output logic                 rb_valid
`endif
);

    cfg_state_e state;
    cfg_state_e state_nxt;
    logic       load;
    logic       shift;
    logic       msb;
    logic       all_shifted;

    mlblock_cfg_shifter #(
        .WIDTH (CHAIN_LEN),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .shift       (shift),
        .word        (cfg_word),
        .msb         (msb),
        .all_shifted (all_shifted)
    );

    // shift marks the edge that launches a bit, so config_en/config_in are registered with it.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_valid) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                    shift     = ~hold;
                end
            end
            SHIFT: begin
                if (all_shifted) begin
                    state_nxt = DONE;
                end else begin
                    shift = ~hold;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            config_en <= 1'b0;
            config_in <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            config_en <= shift;
            config_in <= shift & msb;
        end
    end

`ifdef MLBLOCK_CFG_READBACK_EN
    logic [CHAIN_LEN-1:0] rb_sr;

    // The final tail bit arrives on the same edge that enters DONE, so it is folded in directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_sr    <= '0;
            rb_word  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (config_en) begin
                rb_sr <= {rb_sr[CHAIN_LEN-2:0], config_out};
            end
            if (state == SHIFT && state_nxt == DONE) begin
                rb_word  <= {rb_sr[CHAIN_LEN-2:0], config_out};
                rb_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_config_out;
    assign unused_config_out = config_out;
`endif

endmodule

// File: tb/tb_mlblock_config_loader.sv
// Directed bench for mlblock_config_loader with a behavioural 8-stage chain on its serial pins.
module tb_mlblock_config_loader;

    localparam int L = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [L-1:0] cfg_word;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         hold;
    logic         config_en;
    logic         config_in;
    logic         config_out;
    logic         busy;
    logic         done;
`ifdef MLBLOCK_CFG_READBACK_EN
    logic [L-1:0] rb_word;
    logic         rb_valid;
    logic [L-1:0] rb_at_done;
    logic         rbv_at_done;
`endif

    logic [L-1:0] chain  = '0;
    logic [L-1:0] bitlog = '0;
    int n_en      = 0;
    int zero_viol = 0;
    int en_base   = 0;
    int n_cmp     = 0;
    int n_bad     = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    mlblock_config_loader #(.CHAIN_LEN(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .hold       (hold),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .busy       (busy),
        .done       (done)
`ifdef MLBLOCK_CFG_READBACK_EN
        ,
        .rb_word    (rb_word),
        .rb_valid   (rb_valid)
`endif
    );

    // Chain model: stage 0 takes config_in, the tail feeds config_out.
    assign config_out = chain[L-1];
    always @(posedge clk) if (config_en) chain <= {chain[L-2:0], config_in};

    always @(negedge clk) begin
        if (config_en) begin
            n_en   <= n_en + 1;
            bitlog <= {bitlog[L-2:0], config_in};
        end else if (config_in) begin
            zero_viol <= zero_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [L-1:0] word, input logic h0);
        for (int k = 0; k < 40 && cfg_ready !== 1'b1; k++) @(negedge clk);
        en_base   = n_en;
        cfg_word  = word;
        cfg_valid = 1'b1;
        hold      = h0;
    endtask

    // Entered one cycle after the accept edge; hmask[k] is hold during accept-cycle + k.
    task automatic wait_done(input logic [63:0] hmask, output int lt);
        lt = -1;
        for (int k = 1; k < 48; k++) begin
            hold = hmask[k];
            @(negedge clk);
            if (done) begin
                lt = k;
`ifdef MLBLOCK_CFG_READBACK_EN
                rb_at_done  = rb_word;
                rbv_at_done = rb_valid;
`endif
                break;
            end
            @(posedge clk); #1;
        end
        hold = 1'b0;
    endtask

    task automatic run_load(input logic [L-1:0] word, input logic [63:0] hmask, output int lt);
        start_load(word, hmask[0]);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        wait_done(hmask, lt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b1;
        cfg_word  = 8'h55;
        hold      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_en",    32'(config_en), 32'd0);
        chk("rst_in",    32'(config_in), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
`ifdef MLBLOCK_CFG_READBACK_EN
        chk("rst_rb_word",  32'(rb_word),  32'd0);
        chk("rst_rb_valid", 32'(rb_valid), 32'd0);
`endif
        reset     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_accept", 32'(busy), 32'd0);

        run_load(8'hA5, 64'd0, lat);
        chk("basic_lat",   32'(lat),        32'd9);
        chk("basic_en",    32'(n_en - en_base), 32'd8);
        chk("basic_chain", 32'(chain),      32'hA5);
        chk("basic_bits",  32'(bitlog),     32'hA5);

        run_load(8'h3C, 64'd0, lat);
        chk("pre_chain", 32'(chain), 32'h3C);
        run_load(8'hFF, 64'd0, lat);
        chk("rb1_chain", 32'(chain), 32'hFF);
`ifdef MLBLOCK_CFG_READBACK_EN
        chk("rb1_word",  32'(rb_at_done),  32'h3C);
        chk("rb1_valid", 32'(rbv_at_done), 32'd1);
`endif
        run_load(8'h00, 64'd0, lat);
        chk("rb2_chain", 32'(chain), 32'h00);
`ifdef MLBLOCK_CFG_READBACK_EN
        chk("rb2_word",  32'(rb_at_done), 32'hFF);
`endif

        run_load(8'h81, 64'h0000_0000_0000_041C, lat);
        chk("hold_lat",   32'(lat),            32'd13);
        chk("hold_en",    32'(n_en - en_base), 32'd8);
        chk("hold_chain", 32'(chain),          32'h81);

        start_load(8'h0F, 1'b0);
        @(posedge clk); #1;
        cfg_word = 8'h55;
        wait_done(64'd0, lat);
        chk("ign_lat",   32'(lat),   32'd9);
        chk("ign_chain", 32'(chain), 32'h0F);
        @(negedge clk);
        chk("ign_ready", 32'(cfg_ready), 32'd1);
        en_base = n_en;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        wait_done(64'd0, lat);
        chk("ign2_lat",   32'(lat),   32'd9);
        chk("ign2_chain", 32'(chain), 32'h55);

        start_load(8'hE7, 1'b0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_en_cnt", 32'(n_en - en_base), 32'd4);
        chk("mid_en",     32'(config_en), 32'd0);
        chk("mid_done",   32'(done),      32'd0);
        chk("mid_ready",  32'(cfg_ready), 32'd1);
        chk("mid_busy",   32'(busy),      32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("mid_no_done", 32'(seen), 32'd0);

        run_load(8'hC3, 64'd0, lat);
        chk("post_lat",   32'(lat),            32'd9);
        chk("post_en",    32'(n_en - en_base), 32'd8);
        chk("post_chain", 32'(chain),          32'hC3);

        @(negedge clk);
        chk("idle_in_zero", 32'(zero_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
